// File: rtl/csa_accumulator_if.sv
// Stream bus for csa_accumulator: operand beats in, resolved packet sum out.
// master = the environment side, slave = the accumulator.
interface csa_accumulator_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/csa_accumulator.sv
// Streaming unsigned accumulator. Beats are folded into a redundant sum/carry
// pair with one 3:2 compression per beat; at end of packet the pair is resolved
// CHUNK bits per cycle by a small carry-propagate adder.
// Optional: define CSA_ACC_SATURATE_EN to clamp an overflowed result to all ones.
module csa_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned CHUNK     = 8
) (
  input logic               clk,
  input logic               nreset,
  csa_accumulator_if.slave  bus
);

  localparam int unsigned NCHUNK = (ACC_WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PAD    = NCHUNK * CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StOutput} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [ACC_WIDTH-1:0] carry_q, carry_d;
  logic [PAD-1:0]       res_q, res_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 cin_q, cin_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_out_q, ovf_out_d;

  logic [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH-1:0] maj;
  logic                 accept;
  logic [PAD-1:0]       sum_pad, carry_pad;
  logic [CHUNK-1:0]     s_chunk, c_chunk;
  logic [CHUNK:0]       chunk_add;
  logic [PAD-1:0]       res_next;
  logic [PAD:0]         res_full;
  logic                 hi_ovf;
  logic                 ovf_final;

  assign x      = ACC_WIDTH'(bus.in_data);
  assign maj    = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);
  assign accept = bus.in_valid & bus.in_ready;

  // Redundant pair padded to whole chunks so a partial last chunk needs no special case.
  assign sum_pad   = PAD'(sum_q);
  assign carry_pad = PAD'(carry_q);
  assign s_chunk   = sum_pad[k_q*CHUNK +: CHUNK];
  assign c_chunk   = carry_pad[k_q*CHUNK +: CHUNK];
  assign chunk_add = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK + 1)'(cin_q);

  // Splice the current chunk into the result; anything at or above ACC_WIDTH is overflow.
  always_comb begin
    res_next = res_q;
    res_next[k_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
    res_full = {chunk_add[CHUNK], res_next};
    hi_ovf   = |(res_full >> ACC_WIDTH);
  end

  assign ovf_final = ovf_q | hi_ovf;

  // Next-state: accumulate, resolve chunk by chunk, then hold the result until taken.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    res_d     = res_q;
    k_d       = k_q;
    cin_d     = cin_q;
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          sum_d   = sum_q ^ carry_q ^ x;
          carry_d = maj << 1;
          // Carry leaving the top bit is lost from the pair, so remember it.
          ovf_d   = ovf_q | maj[ACC_WIDTH-1];
          k_d     = '0;
          cin_d   = 1'b0;
          state_d = bus.in_last ? StResolve : StAccum;
        end
      end
      StResolve: begin
        res_d = res_next;
        cin_d = chunk_add[CHUNK];
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) begin
          ovf_d     = ovf_final;
          ovf_out_d = ovf_final;
          state_d   = StOutput;
`ifdef CSA_ACC_SATURATE_EN
          if (ovf_final) res_d = '1;
`else
`endif
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          sum_d   = '0;
          carry_d = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      carry_q   <= '0;
      res_q     <= '0;
      k_q       <= '0;
      cin_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      res_q     <= res_d;
      k_q       <= k_d;
      cin_q     <= cin_d;
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bus.in_ready     = (state_q == StIdle) || (state_q == StAccum);
  assign bus.out_valid    = (state_q == StOutput);
  assign bus.out_data     = res_q[ACC_WIDTH-1:0];
  assign bus.out_overflow = ovf_out_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: table of packets plus hand-written
// overflow, backpressure, valid-gap and mid-resolve reset sequences.
module tb_csa_accumulator;

  logic clk;
  logic nreset;

  csa_accumulator_if #(.WIDTH(16), .ACC_WIDTH(24)) bus ();

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(24), .CHUNK(8)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    int unsigned n;
    logic [15:0] d [4];
    logic [23:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Present one beat at a negedge and wait (bounded) until it is accepted.
  task automatic send(input logic [15:0] d, input logic last);
    int   cnt;
    logic acc;
    cnt = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!acc && cnt < 50) begin
      acc = bus.in_ready;
      @(negedge clk);
      cnt++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    chk("beat_accepted", 32'(acc), 32'd1);
  endtask

  // Idle cycles with in_valid low; in_last high and junk data must be ignored.
  task automatic gap(input int unsigned n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    bus.in_data  = 16'hFFFF;
    repeat (n) @(negedge clk);
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Wait (bounded) for out_valid with out_ready high, check result and handshake.
  task automatic get_result(input string name, input logic [23:0] exp, input logic ovf,
                            input logic check_lat);
    int cnt;
    cnt = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (check_lat) chk({name, "_latency"}, 32'(cnt), 32'd3);
    chk({name, "_data"}, 32'(bus.out_data), 32'(exp));
    chk({name, "_ovf"}, 32'(bus.out_overflow), 32'(ovf));
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_valid_dropped"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [23:0] exp_big;
    int          cnt;
    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{1, '{16'h1234, 16'h0, 16'h0, 16'h0}, 24'h001234, 1'b0};
    vecs[1] = '{3, '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0}, 24'h01FFFF, 1'b0};
    vecs[2] = '{2, '{16'h0005, 16'h0007, 16'h0, 16'h0}, 24'h00000C, 1'b0};
    vecs[3] = '{4, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 24'h00000A, 1'b0};
    vecs[4] = '{1, '{16'h0009, 16'h0, 16'h0, 16'h0}, 24'h000009, 1'b0};
    vecs[5] = '{4, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 24'h03FFFC, 1'b0};
    vecs[6] = '{2, '{16'h8000, 16'h8001, 16'h0, 16'h0}, 24'h010001, 1'b0};

`ifdef CSA_ACC_SATURATE_EN
    exp_big = 24'hFFFFFF;
`else
    exp_big = 24'h2BFED4;
`endif

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    nreset        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_overflow), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Table of packets, each followed by an immediate result handshake.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++) send(vecs[i].d[j], j == int'(vecs[i].n) - 1);
      get_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ovf, 1'b1);
    end

    // Valid gaps with in_last high on unaccepted cycles.
    for (int j = 1; j <= 4; j++) begin
      gap(1 + $urandom_range(0, 2));
      send(16'(j), j == 4);
    end
    get_result("gaps", 24'h00000A, 1'b0, 1'b1);

    // Backpressure: result held while the source pushes a beat that must be ignored.
    send(16'h0100, 1'b0);
    send(16'h0023, 1'b1);
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0005;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(bus.out_data), 32'h000123);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    get_result("bp_release", 24'h000123, 1'b0, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0007, 1'b1);
    get_result("bp_next", 24'h00000C, 1'b0, 1'b1);

    // Overflow: 300 x 0xFFFF, true sum 0x12BFED4.
    for (int j = 0; j < 300; j++) send(16'hFFFF, j == 299);
    get_result("overflow", exp_big, 1'b1, 1'b1);

    // Reset while resolving chunk 1; outputs must clear at once.
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_out_ovf", 32'(bus.out_overflow), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    send(16'h0009, 1'b1);
    get_result("after_rst", 24'h000009, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
